// File: rtl/dut_d_ff_pkg.sv
// Shared constants and helpers for the dut_d_ff register stage.
// Holds the pipeline-depth limit and the parameter legality check.
package dut_d_ff_pkg;

  localparam int MAX_STAGES = 16;
  localparam int MIN_STAGES = 1;

  function automatic bit stages_ok(input int stages);
    return (stages >= MIN_STAGES) && (stages <= MAX_STAGES);
  endfunction

  function automatic bit width_ok(input int width);
    return width >= 1;
  endfunction

endpackage

// File: rtl/dut_d_ff_stage.sv
// One WIDTH-bit register with asynchronous active-high reset.
// Reset wins over a coincident rising clock edge.
module dut_d_ff_stage #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture d on each rising edge; reset forces RESET_VALUE at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VALUE;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/dut_d_ff.sv
// Parameterizable D flip-flop / delay line of STAGES cascaded registers.
// rst_n is active-high despite its name; it is used unsynchronized.
module dut_d_ff
  import dut_d_ff_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter int               STAGES      = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reject illegal configurations while elaborating.
  if (!stages_ok(STAGES)) begin : g_bad_stages
    $fatal(1, "dut_d_ff: STAGES=%0d outside 1..%0d", STAGES, MAX_STAGES);
  end
  if (!width_ok(WIDTH)) begin : g_bad_width
    $fatal(1, "dut_d_ff: WIDTH=%0d must be at least 1", WIDTH);
  end

  logic [WIDTH-1:0] stage [STAGES];

  // Chain of registers: stage 0 takes d, each later stage its predecessor.
  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic [WIDTH-1:0] din;
    if (g == 0) begin : g_first
      assign din = d;
    end else begin : g_next
      assign din = stage[g-1];
    end
    dut_d_ff_stage #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .clk (clk),
      .rst (rst_n),
      .d   (din),
      .q   (stage[g])
    );
  end

  assign q = stage[STAGES-1];

endmodule

// File: tb/tb_dut_d_ff.sv
// Directed bench for dut_d_ff in three configurations.
// Default DFF, a 3-deep byte delay line and a non-zero reset value.
module tb_dut_d_ff;

  logic       clk;
  logic       rst_a, rst_b, rst_c;
  logic       d_a, q_a;
  logic [7:0] d_b, q_b;
  logic [7:0] d_c, q_c;

  int checks = 0;
  int errors = 0;

  dut_d_ff u_a (
    .clk   (clk),
    .rst_n (rst_a),
    .d     (d_a),
    .q     (q_a)
  );

  dut_d_ff #(
    .WIDTH  (8),
    .STAGES (3)
  ) u_b (
    .clk   (clk),
    .rst_n (rst_b),
    .d     (d_b),
    .q     (q_b)
  );

  dut_d_ff #(
    .WIDTH       (8),
    .STAGES      (1),
    .RESET_VALUE (8'hA5)
  ) u_c (
    .clk   (clk),
    .rst_n (rst_c),
    .d     (d_c),
    .q     (q_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic at(input longint t);
    if (t > longint'($time)) #(t - longint'($time));
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    d_a = 1'b0; d_b = 8'h00; d_c = 8'hFF;

    at(1);
    chk("a_reset", {7'd0, q_a}, 8'h00);
    chk("b_reset", q_b, 8'h00);
    chk("c_reset", q_c, 8'hA5);

    at(2);  rst_a = 1'b0;
    at(4);  d_a = 1'b1;
    at(6);  chk("a_edge5", {7'd0, q_a}, 8'h01);
    at(8);  d_a = 1'b0;
    at(12); d_a = 1'b1;
    at(16); chk("a_edge15", {7'd0, q_a}, 8'h01);
    d_a = 1'b0;
    at(20); d_a = 1'b1;
    at(24); d_a = 1'b0;
    at(26); chk("a_edge25", {7'd0, q_a}, 8'h00);
    at(30); d_a = 1'b1;
    at(36); chk("a_edge35", {7'd0, q_a}, 8'h01);

    at(42); rst_a = 1'b1;
    at(43); rst_a = 1'b0;
    chk("a_pulse", {7'd0, q_a}, 8'h00);
    at(44); chk("a_pulse_hold", {7'd0, q_a}, 8'h00);
    at(46); chk("a_after_pulse", {7'd0, q_a}, 8'h01);

    at(55); rst_a = 1'b1; d_a = 1'b1;
    at(56); chk("a_rst_on_edge", {7'd0, q_a}, 8'h00);
    rst_a = 1'b0;
    at(58); d_a = 1'b0;
    at(66); chk("a_edge65", {7'd0, q_a}, 8'h00);
    at(68); d_a = 1'b1;
    at(72); d_a = 1'b0;
    at(74); chk("a_glitch_mid", {7'd0, q_a}, 8'h00);
    at(76); chk("a_glitch_edge", {7'd0, q_a}, 8'h00);

    at(82); rst_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      logic [7:0] exp_b;
      d_b = 8'h11 * 8'(i + 1);
      exp_b = (i < 2) ? 8'h00 : 8'h11 * 8'(i - 1);
      @(posedge clk);
      #1;
      chk($sformatf("b_step%0d", i), q_b, exp_b);
    end

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("c_hold%0d", i), q_c, 8'hA5);
    end
    rst_c = 1'b0;
    chk("c_release", q_c, 8'hA5);
    @(posedge clk);
    #1;
    chk("c_first", q_c, 8'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
